// File: rtl/n_bit_comp_pkg.sv
// Shared result encoding for the registered magnitude comparator.
// Bit order of cmp_res_t is {gt, eq, lt}, which maps directly onto {O1, O2, O3}.
package n_bit_comp_pkg;

    typedef logic [2:0] cmp_res_t;

    localparam cmp_res_t CMP_GT   = 3'b100;
    localparam cmp_res_t CMP_EQ   = 3'b010;
    localparam cmp_res_t CMP_LT   = 3'b001;
    localparam cmp_res_t CMP_NONE = 3'b000;

    // Pack the cascade outputs into the result encoding.
    function automatic cmp_res_t pack_res(input logic gt, input logic eq, input logic lt);
        return {gt, eq, lt};
    endfunction

endpackage

// File: rtl/n_bit_comp_comp_slice.sv
// One-bit compare cell of the MSB-first cascade; a decision made upstream is passed through unchanged.
// Latency: combinational.
// Backpressure: none; pure combinational logic.
module comp_slice (
    input  logic a_bit,
    input  logic b_bit,
    input  logic gt_in,
    input  logic lt_in,
    input  logic eq_in,
    input  logic invert,
    output logic gt_out,
    output logic lt_out,
    output logic eq_out
);

    logic a_hi;
    logic b_hi;
    logic bit_gt;
    logic bit_lt;

    assign a_hi = a_bit & ~b_bit;
    assign b_hi = ~a_bit & b_bit;

    // invert flips the sense of this bit, used for the two's-complement sign bit
    assign bit_gt = invert ? b_hi : a_hi;
    assign bit_lt = invert ? a_hi : b_hi;

    assign gt_out = gt_in | (eq_in & bit_gt);
    assign lt_out = lt_in | (eq_in & bit_lt);
    assign eq_out = eq_in & ~(a_bit ^ b_bit);

endmodule

// File: rtl/n_bit_comp.sv
// Registered N-bit magnitude comparator producing one-hot {O1:gt, O2:eq, O3:lt}.
// Latency: 1 cycle from an en=1 edge; outputs read all-zero after reset until the first capture.
// Backpressure: none; en=0 holds the last registered result.
module n_bit_comp
    import n_bit_comp_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             O1,
    output logic             O2,
    output logic             O3
);

    // Chain index k carries the state above bit k; index WIDTH is the "nothing decided yet" seed.
    logic [WIDTH:0] gt_c;
    logic [WIDTH:0] lt_c;
    logic [WIDTH:0] eq_c;
    cmp_res_t       res_nxt;
    cmp_res_t       res_q;

    assign gt_c[WIDTH] = 1'b0;
    assign lt_c[WIDTH] = 1'b0;
    assign eq_c[WIDTH] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        comp_slice u_slice (
            .a_bit  (A[i]),
            .b_bit  (B[i]),
            .gt_in  (gt_c[i+1]),
            .lt_in  (lt_c[i+1]),
            .eq_in  (eq_c[i+1]),
            .invert (((i == WIDTH - 1) && (SIGNED != 0)) ? 1'b1 : 1'b0),
            .gt_out (gt_c[i]),
            .lt_out (lt_c[i]),
            .eq_out (eq_c[i])
        );
    end

    assign res_nxt = pack_res(gt_c[0], eq_c[0], lt_c[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q <= CMP_NONE;
        end else if (en) begin
            res_q <= res_nxt;
        end
    end

    assign {O1, O2, O3} = res_q;

endmodule

// File: tb/tb_n_bit_comp.sv
// Directed bench for n_bit_comp: unsigned and signed 4-bit instances driven by shared stimulus.
module tb_n_bit_comp;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] A;
    logic [3:0] B;
    logic       u_o1, u_o2, u_o3;
    logic       s_o1, s_o2, s_o3;

    int vectors;
    int errors;

    localparam logic [2:0] GT   = 3'b100;
    localparam logic [2:0] EQ   = 3'b010;
    localparam logic [2:0] LT   = 3'b001;
    localparam logic [2:0] NONE = 3'b000;

    n_bit_comp #(.WIDTH(4), .SIGNED(0)) dut_u (
        .clk (clk), .rst (rst), .en (en), .A (A), .B (B),
        .O1  (u_o1), .O2 (u_o2), .O3 (u_o3)
    );

    n_bit_comp #(.WIDTH(4), .SIGNED(1)) dut_s (
        .clk (clk), .rst (rst), .en (en), .A (A), .B (B),
        .O1  (s_o1), .O2 (s_o2), .O3 (s_o3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Drive operands at a falling edge, let one rising edge pass, then check both instances.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic e, input logic [2:0] exp_u, input logic [2:0] exp_s);
        @(negedge clk);
        A  = a;
        B  = b;
        en = e;
        @(negedge clk);
        chk({tag, "_u"}, {u_o1, u_o2, u_o3}, exp_u);
        chk({tag, "_s"}, {s_o1, s_o2, s_o3}, exp_s);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        en  = 1'b1;
        A   = 4'b0101;
        B   = 4'b0011;
        rst = 1'b1;
        #1;
        chk("reset_async_u", {u_o1, u_o2, u_o3}, NONE);
        chk("reset_async_s", {s_o1, s_o2, s_o3}, NONE);

        // en is ignored while reset is held across a rising edge
        @(negedge clk);
        @(negedge clk);
        chk("reset_hold_u", {u_o1, u_o2, u_o3}, NONE);
        chk("reset_hold_s", {s_o1, s_o2, s_o3}, NONE);
        rst = 1'b0;

        step("first_eq", 4'b0000, 4'b0000, 1'b1, EQ, EQ);

        // Walking one on A with B=0
        step("walk_a0", 4'b0001, 4'b0000, 1'b1, GT, GT);
        step("walk_a1", 4'b0010, 4'b0000, 1'b1, GT, GT);
        step("walk_a2", 4'b0100, 4'b0000, 1'b1, GT, GT);
        step("walk_a3", 4'b1000, 4'b0000, 1'b1, GT, LT);

        // Walking one on B with A=0
        step("walk_b0", 4'b0000, 4'b0001, 1'b1, LT, LT);
        step("walk_b1", 4'b0000, 4'b0010, 1'b1, LT, LT);
        step("walk_b2", 4'b0000, 4'b0100, 1'b1, LT, LT);
        step("walk_b3", 4'b0000, 4'b1000, 1'b1, LT, GT);

        // Equality patterns
        step("eq_1100", 4'b1100, 4'b1100, 1'b1, EQ, EQ);
        step("eq_0110", 4'b0110, 4'b0110, 1'b1, EQ, EQ);
        step("eq_1111", 4'b1111, 4'b1111, 1'b1, EQ, EQ);

        // Lower bits decide once the MSBs match; signed -1 vs -2 and -8 vs 7
        step("low_bits", 4'b1111, 4'b1110, 1'b1, GT, GT);
        step("sign_span", 4'b1000, 4'b0111, 1'b1, GT, LT);
        step("lsb_lt", 4'b0110, 4'b0111, 1'b1, LT, LT);

        // Hold with en low, then resume
        step("hold_cap", 4'b0001, 4'b0000, 1'b1, GT, GT);
        step("hold_1", 4'b0000, 4'b0001, 1'b0, GT, GT);
        step("hold_2", 4'b0000, 4'b0001, 1'b0, GT, GT);
        step("hold_rel", 4'b0000, 4'b0001, 1'b1, LT, LT);

        // Mid-stream reset pulse between edges
        step("ms_a", 4'b1010, 4'b0101, 1'b1, GT, LT);
        step("ms_b", 4'b0101, 4'b1010, 1'b1, LT, GT);
        A   = 4'b0011;
        B   = 4'b0011;
        rst = 1'b1;
        #1;
        chk("ms_rst_u", {u_o1, u_o2, u_o3}, NONE);
        chk("ms_rst_s", {s_o1, s_o2, s_o3}, NONE);
        rst = 1'b0;
        #1;
        chk("ms_rel_u", {u_o1, u_o2, u_o3}, NONE);
        chk("ms_rel_s", {s_o1, s_o2, s_o3}, NONE);
        step("ms_resume", 4'b0011, 4'b0011, 1'b1, EQ, EQ);
        step("ms_next", 4'b1110, 4'b0010, 1'b1, GT, LT);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/n_bit_comp.md
# n_bit_comp

Registered N-bit magnitude comparator that reports whether operand A is greater than, equal to, or less than operand B. Each result is a one-hot, three-flag registered output. It sits in datapath control logic wherever a registered compare decision is needed, such as threshold checks or sort/select steering. The width is a parameter; the default build is 4 bits, unsigned.

## Interface
- WIDTH, 4: operand width in bits; legal range 1..32.
- SIGNED, 0: 0 selects unsigned compare; 1 selects two's-complement compare.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; when high, the compare result of A/B is registered at the next clk edge.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- O1  output  1  A > B.
- O2  output  1  A == B.
- O3  output  1  A < B.

## Operation
- Compare path is combinational, evaluated MSB-first through a cascade of per-bit slices:
  - Each slice passes along "decided-greater", "decided-less" and "still-equal".
  - The first differing bit from the MSB decides the result.
  - If no bit differs, the result is equal.
- SIGNED=1: the MSB slice's decision is inverted. A=1, B=0 at the MSB means A < B. Lower bits compare as unsigned.
- Registered outputs are mutually exclusive: exactly one of O1/O2/O3 is high after any capture.
- After reset, O1=O2=O3=0 until the first capture. The all-zero state means "no result yet" and is the only legal non-one-hot state.
- en=0: outputs hold their last value. The A/B values are ignored.
- No X propagation requirement beyond standard synthesis semantics. Inputs are sampled only at clk edges where en=1.

## Timing
- Latency: 1 cycle. A/B presented with en=1 before edge k appear on O1..O3 after edge k.
- Throughput: one compare per cycle. Back-to-back en=1 cycles update every cycle.
- Reset:
  - rst asserted clears O1..O3 to 0 immediately, with no clock needed.
  - While rst=1, en is ignored.
  - The first capture occurs at the first clk edge with rst=0 and en=1.
- Reset mid-stream: a compare in flight is discarded. Outputs read 0 until the next capture.
- Simultaneous rst release and clk edge: reset dominates for that edge. No capture occurs.
- The combinational cascade must close timing at the target clock for WIDTH up to 32. A single register stage holds the three flags.

## Structure
- Shared package holds:
  - The result encoding constants: CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001, CMP_NONE=3'b000. These map to {O1,O2,O3}.
  - A typedef for the 3-bit result.
- One sub-module, comp_slice: a 1-bit compare cell.
  - Inputs: a_bit, b_bit, gt_in, lt_in, eq_in, invert.
  - Outputs: gt_out, lt_out, eq_out.
- Top level:
  - Generates WIDTH slices MSB-to-LSB.
  - The MSB slice gets invert=SIGNED.
  - Top level also holds the output register with async reset and the en hold.

## Test plan
- Reset: assert rst with arbitrary A/B -> O1=O2=O3=0 immediately. Release rst, en=1, A=4'b0000, B=4'b0000 -> O2=1, O1=O3=0 after one edge.
- Walking-1 on A (B=0): A=0001/0010/0100/1000 each with en=1 -> O1=1, O2=O3=0 one cycle after each. With SIGNED=1, A=1000 -> O3=1.
- Walking-1 on B (A=0): B=0001/0010/0100/1000 -> O3=1 each. With SIGNED=1, B=1000 -> O1=1.
- Equality: A=B in turn for 1100, 0110 and 1111 -> O2=1 for each, O1=O3=0.
- Hold: capture A=0001, B=0000 (O1=1), then drop en and change to A=0000, B=0001 -> O1 stays 1. Raise en -> O3=1 next edge.
- Mid-stream reset: en=1 toggling results every cycle. Pulse rst between edges -> outputs 0 asynchronously. They resume one edge after release.
